// File: rtl/sec_encoder_awe_52bits_clk_pkg.sv
// sec_awe_pkg: widths, Hamming position table, FSM states and
// codeword packing shared by the 52-bit AWE SEC encoder.
package sec_awe_pkg;

   localparam int DATA_W  = 52;
   localparam int CW_W    = 61;
   localparam int CHUNK_W = 13;
   localparam int PAR_W   = 6;
   localparam int N_CHUNK = DATA_W / CHUNK_W;

   typedef logic [PAR_W-1:0] pos_t;

   // 1-based Hamming position of each data bit: the
   // non-power-of-two positions 3..58 in ascending order.
   localparam pos_t DPOS [0:DATA_W-1] = '{
      6'd3,  6'd5,  6'd6,  6'd7,  6'd9,  6'd10, 6'd11,
      6'd12, 6'd13, 6'd14, 6'd15, 6'd17, 6'd18, 6'd19,
      6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25, 6'd26,
      6'd27, 6'd28, 6'd29, 6'd30, 6'd31, 6'd33, 6'd34,
      6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd40, 6'd41,
      6'd42, 6'd43, 6'd44, 6'd45, 6'd46, 6'd47, 6'd48,
      6'd49, 6'd50, 6'd51, 6'd52, 6'd53, 6'd54, 6'd55,
      6'd56, 6'd57, 6'd58
   };

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } state_t;

   // Scatter data and check bits into the codeword layout.
   function automatic logic [CW_W-1:0] build_cw(
      input logic [DATA_W-1:0] data,
      input logic [PAR_W-1:0]  par,
      input logic              ovr,
      input logic [1:0]        tag
   );
      logic [CW_W-1:0] cw;
      cw = '0;
      for (int i = 0; i < DATA_W; i++)
         cw[int'(DPOS[i]) - 1] = data[i];
      for (int j = 0; j < PAR_W; j++)
         cw[(1 << j) - 1] = par[j];
      cw[58]    = ovr;
      cw[60:59] = tag;
      return cw;
   endfunction

endpackage

// File: rtl/sec_encoder_awe_52bits_clk_if.sv
// Word-in / codeword-out valid-ready bundle for the encoder.
// slave: encoder side; master: producer/consumer side.
interface sec_encoder_awe_52bits_clk_if;
   import sec_awe_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] D;
   logic              out_valid;
   logic              out_ready;
   logic [CW_W-1:0]   W;

   modport slave (
      input  in_valid, D, out_ready,
      output in_ready, out_valid, W
   );

   modport master (
      output in_valid, D, out_ready,
      input  in_ready, out_valid, W
   );

endinterface

// File: rtl/sec_encoder_awe_52bits_clk_chunk_parity.sv
// sec_chunk_parity: partial check vector and data parity of one
// 13-bit chunk. in: chunk, idx; out: pvec, cpar.
module sec_chunk_parity
   import sec_awe_pkg::*;
(
   input  logic [CHUNK_W-1:0] chunk,
   input  logic [1:0]         idx,
   output logic [PAR_W-1:0]   pvec,
   output logic               cpar
);

   // XOR of the positions of all set bits is exactly the
   // set of check bits those data bits contribute to.
   always_comb begin
      pvec = '0;
      for (int k = 0; k < CHUNK_W; k++) begin
         if (chunk[k])
            pvec = pvec ^ DPOS[int'(idx) * CHUNK_W + k];
      end
   end

   assign cpar = ^chunk;

endmodule

// File: rtl/sec_encoder_awe_52bits_clk.sv
// Multi-cycle Hamming(58,52)+parity encoder with 2-bit tag.
// Ports: clk, rst (async high), bus (valid/ready in, codeword out).
module sec_encoder_awe_52bits_clk
   import sec_awe_pkg::*;
(
   input logic                          clk,
   input logic                          rst,
   sec_encoder_awe_52bits_clk_if.slave  bus
);

   state_t            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [1:0]        tag_q, tag_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [PAR_W-1:0]  par_q, par_d;
   logic              ovr_q, ovr_d;
   logic [CW_W-1:0]   w_q, w_d;

   logic [CHUNK_W-1:0] chunk;
   logic [PAR_W-1:0]   pvec;
   logic               cpar;
   logic [PAR_W-1:0]   par_nx;
   logic               ovr_nx;

   assign chunk = data_q[cnt_q * CHUNK_W +: CHUNK_W];

   sec_chunk_parity u_chunk (
      .chunk (chunk),
      .idx   (cnt_q),
      .pvec  (pvec),
      .cpar  (cpar)
   );

   assign par_nx = par_q ^ pvec;
   assign ovr_nx = ovr_q ^ cpar;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tag_d   = tag_q;
      data_d  = data_q;
      par_d   = par_q;
      ovr_d   = ovr_q;
      w_d     = w_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               data_d  = bus.D;
               par_d   = '0;
               ovr_d   = 1'b0;
               cnt_d   = 2'd0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            par_d = par_nx;
            ovr_d = ovr_nx;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'(N_CHUNK - 1)) begin
               // Overall parity also covers the check bits.
               ovr_d   = ovr_nx ^ (^par_nx);
               w_d     = build_cw(data_q, par_nx,
                                  ovr_d, tag_q);
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               tag_d   = tag_q + 2'd1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tag_q   <= '0;
         data_q  <= '0;
         par_q   <= '0;
         ovr_q   <= 1'b0;
         w_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
         par_q   <= par_d;
         ovr_q   <= ovr_d;
         w_q     <= w_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.W         = w_q;

endmodule

// File: tb/tb_sec_encoder_awe_52bits_clk.sv
// Directed self-checking bench for sec_encoder_awe_52bits_clk.
// Reference encoder/decoder models are built independently below.
module tb_sec_encoder_awe_52bits_clk;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [1:0] exp_tag = 2'd0;

   always #5 clk = ~clk;

   sec_encoder_awe_52bits_clk_if bus ();

   sec_encoder_awe_52bits_clk dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [60:0] enc_model(
      input logic [51:0] d,
      input logic [1:0]  tag
   );
      logic [60:0] cw;
      int i;
      logic b;
      cw = '0;
      i  = 0;
      for (int p = 1; p <= 58; p++) begin
         if ((p & (p - 1)) != 0) begin
            cw[p-1] = d[i];
            i++;
         end
      end
      for (int j = 0; j < 6; j++) begin
         b = 1'b0;
         for (int p = 1; p <= 58; p++)
            if (((p >> j) & 1) == 1) b = b ^ cw[p-1];
         cw[(1 << j) - 1] = b;
      end
      cw[58]    = ^cw[57:0];
      cw[60:59] = tag;
      return cw;
   endfunction

   function automatic logic [51:0] dec_model(
      input logic [60:0] w
   );
      int s;
      int i;
      logic [51:0] d;
      s = 0;
      i = 0;
      d = '0;
      for (int p = 1; p <= 58; p++)
         if (w[p-1]) s = s ^ p;
      if (s >= 1 && s <= 58) w[s-1] = ~w[s-1];
      for (int p = 1; p <= 58; p++) begin
         if ((p & (p - 1)) != 0) begin
            d[i] = w[p-1];
            i++;
         end
      end
      return d;
   endfunction

   task automatic check(
      input string       tag,
      input logic [63:0] got,
      input logic [63:0] exp
   );
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_w", 64'(bus.W), 64'd0);
      tick;
      rst = 1'b0;
      exp_tag = 2'd0;
   endtask

   task automatic accept(input logic [51:0] d);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.D        = d;
      while (!bus.in_ready && n < 20) begin
         tick;
         n++;
      end
      check("accept_wait", 64'(bus.in_ready), 64'd1);
      tick;
      bus.in_valid = 1'b0;
      bus.D        = ~d;
   endtask

   task automatic finish_word(
      input  logic [51:0] d,
      input  int          stall,
      output logic [60:0] got
   );
      int lat;
      bit bad;
      lat = 0;
      bad = 1'b0;
      while (!bus.out_valid && lat < 20) begin
         if (bus.in_ready) bad = 1'b1;
         tick;
         lat++;
      end
      check("latency", 64'(lat), 64'd4);
      got = bus.W;
      check("codeword", 64'(got), 64'(enc_model(d, exp_tag)));
      for (int s = 0; s < stall; s++) begin
         if (s == 3) bus.in_valid = 1'b1;
         if (s == 4) bus.in_valid = 1'b0;
         tick;
         if (bus.W !== got || !bus.out_valid || bus.in_ready)
            bad = 1'b1;
      end
      bus.in_valid = 1'b0;
      check("busy_hold", 64'(bad), 64'd0);
      bus.out_ready = 1'b1;
      tick;
      bus.out_ready = 1'b0;
      check("post_hs", 64'({bus.in_ready, bus.out_valid}),
            64'b10);
      exp_tag = exp_tag + 2'd1;
      if (stall > 0) begin
         tick;
         check("no_queue", 64'(bus.in_ready), 64'd1);
      end
   endtask

   task automatic run_word(
      input  logic [51:0] d,
      input  int          stall,
      output logic [60:0] got
   );
      accept(d);
      finish_word(d, stall, got);
   endtask

   logic [60:0] got;
   logic [60:0] exp_ones;
   logic [51:0] words [0:4];
   logic [1:0]  tags [0:4];
   logic [51:0] last_d;

   initial begin
      words[0] = 52'h123456789ABCD;
      words[1] = 52'hFEDCBA9876543;
      words[2] = 52'h0F0F0F0F0F0F0;
      words[3] = 52'h8000000000001;
      words[4] = 52'h5555555555555;
      tags[0] = 2'd0;
      tags[1] = 2'd1;
      tags[2] = 2'd2;
      tags[3] = 2'd3;
      tags[4] = 2'd0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.D         = '0;
      #1;
      do_reset;

      run_word(52'd0, 0, got);
      check("zero_w", 64'(got), 64'd0);

      do_reset;
      run_word(52'd1, 0, got);
      check("d0_w", 64'(got), 64'h0400000000000007);

      do_reset;
      run_word({52{1'b1}}, 0, got);
      exp_ones = 61'h07FFFFFF7FFF7F7C;
      check("ones_w", 64'(got), 64'(exp_ones));

      do_reset;
      for (int i = 0; i < 5; i++) begin
         run_word(words[i], (i == 1) ? 10 : 0, got);
         check("seq_tag", 64'(got[60:59]), 64'(tags[i]));
      end

      do_reset;
      run_word(words[0], 0, got);
      run_word(words[1], 0, got);
      accept(words[2]);
      tick;
      tick;
      do_reset;
      last_d = words[3];
      run_word(last_d, 0, got);
      check("tag_after_rst", 64'(got[60:59]), 64'd0);

      for (int p = 1; p <= 58; p++) begin
         logic [60:0] w;
         w = got;
         w[p-1] = ~w[p-1];
         check($sformatf("flip_%0d", p),
               64'(dec_model(w)), 64'(last_d));
      end

      $display("TB_RESULT checks=%0d failures=%0d",
               n_checks, n_fail);
      $finish;
   end

endmodule
